// File: rtl/ccip_c1tx_arb_pkg.sv
// Shared types and helpers for the CCI-P C1Tx write-channel arbiter.
// Holds the C1 request header layout and the packet beat-count decode.
package ccip_c1tx_arb_pkg;

    localparam int C1ARB_CNT_W = 32;

    typedef enum logic {
        C1ARB_IDLE,
        C1ARB_BURST
    } t_c1arb_state;

    typedef logic [3:0] t_ccip_c1_req;
    typedef logic [1:0] t_ccip_clLen;

    localparam t_ccip_c1_req eREQ_WRLINE_I = 4'h0;
    localparam t_ccip_c1_req eREQ_WRLINE_M = 4'h1;
    localparam t_ccip_c1_req eREQ_WRPUSH_I = 4'h2;
    localparam t_ccip_c1_req eREQ_WRFENCE  = 4'h4;
    localparam t_ccip_c1_req eREQ_INTR     = 4'h6;

    localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
    localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
    localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

    typedef struct packed {
        logic [5:0]   rsvd2;
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    // Only line writes span several beats; fences and interrupts are always one beat.
    function automatic int c1_pkt_beats(input t_ccip_c1_ReqMemHdr hdr);
        case (hdr.req_type)
            eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I: return int'(hdr.cl_len) + 1;
            default:                                     return 1;
        endcase
    endfunction

endpackage

// File: rtl/ase_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set request
// at or after the start pointer (wrapping), as a one-hot grant and an index.
module ase_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    // Scan from the farthest position back toward start so the closest hit wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                grant                          = '0;
                grant[(int'(start) + k) % N]   = 1'b1;
                idx                            = IDX_W'((int'(start) + k) % N);
                any_valid                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccip_c1tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the CCI-P C1Tx channel among NUM_REQ requesters.
// Define ASE_C1TX_ARB_STATS_EN to enable the per-requester completed-packet counters.
module ccip_c1tx_arbiter
    import ccip_c1tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int HDR_W   = 80,
    parameter int DATA_W  = 512
) (
    input  logic                          clk,
    input  logic                          SoftReset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*HDR_W-1:0]      req_hdr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          c1TxAlmFull,
    output logic                          c1_valid,
    output logic [HDR_W-1:0]              c1_hdr,
    output logic [DATA_W-1:0]             c1_data,
    output logic [NUM_REQ*C1ARB_CNT_W-1:0] stat_pkt_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    t_c1arb_state     state, state_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0] lock_id, lock_id_next;
    logic [1:0]       beats_left, beats_left_next;
    logic [IDX_W-1:0] sel_idx;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [2:0]         pkt_beats [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_beats
        assign pkt_beats[i] =
            3'(c1_pkt_beats(t_ccip_c1_ReqMemHdr'(req_hdr[i*HDR_W +: HDR_W])));
    end

    ase_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .start     (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state      <= C1ARB_IDLE;
            rr_ptr     <= '0;
            lock_id    <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_ptr_next;
            lock_id    <= lock_id_next;
            beats_left <= beats_left_next;
        end
    end

    // AlmFull only gates the start of a packet; an open burst always drains.
    always_comb begin
        state_next      = state;
        rr_ptr_next     = rr_ptr;
        lock_id_next    = lock_id;
        beats_left_next = beats_left;
        req_ready       = '0;
        sel_idx         = pick_idx;
        case (state)
            C1ARB_IDLE: begin
                if (!c1TxAlmFull && pick_any) begin
                    req_ready = pick_grant;
                    if (pkt_beats[pick_idx] == 3'd1) begin
                        rr_ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                    end else begin
                        lock_id_next    = pick_idx;
                        beats_left_next = 2'(pkt_beats[pick_idx] - 3'd1);
                        state_next      = C1ARB_BURST;
                    end
                end
            end
            C1ARB_BURST: begin
                sel_idx = lock_id;
                if (req_valid[lock_id]) begin
                    req_ready[lock_id] = 1'b1;
                    beats_left_next    = beats_left - 2'd1;
                    if (beats_left == 2'd1) begin
                        state_next  = C1ARB_IDLE;
                        rr_ptr_next = (lock_id == LAST_IDX) ? '0 : lock_id + 1'b1;
                    end
                end
            end
            default: state_next = C1ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            c1_valid <= 1'b0;
            c1_hdr   <= '0;
            c1_data  <= '0;
        end else begin
            c1_valid <= |req_ready;
            if (|req_ready) begin
                c1_hdr  <= req_hdr[int'(sel_idx)*HDR_W +: HDR_W];
                c1_data <= req_data[int'(sel_idx)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ASE_C1TX_ARB_STATS_EN
    logic                   pkt_done;
    logic [C1ARB_CNT_W-1:0] pkt_cnt [NUM_REQ];

    // A packet completes on its single beat in IDLE or on the last beat of a burst.
    always_comb begin
        pkt_done = 1'b0;
        if (|req_ready) begin
            if (state == C1ARB_IDLE) begin
                pkt_done = (pkt_beats[pick_idx] == 3'd1);
            end else begin
                pkt_done = (beats_left == 2'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (pkt_done) begin
            pkt_cnt[sel_idx] <= pkt_cnt[sel_idx] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign stat_pkt_cnt[i*C1ARB_CNT_W +: C1ARB_CNT_W] = pkt_cnt[i];
    end
`else
    assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// Self-checking bench for ccip_c1tx_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_ccip_c1tx_arbiter;

    localparam int N  = 4;
    localparam int HW = 80;
    localparam int DW = 512;
`ifdef ASE_C1TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              SoftReset;
    logic [N-1:0]      req_valid;
    logic [N*HW-1:0]   req_hdr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              c1TxAlmFull;
    logic              c1_valid;
    logic [HW-1:0]     c1_hdr;
    logic [DW-1:0]     c1_data;
    logic [N*32-1:0]   stat_pkt_cnt;

    int checks = 0;
    int errors = 0;

    ccip_c1tx_arbiter #(.NUM_REQ(N), .HDR_W(HW), .DATA_W(DW)) dut (
        .clk          (clk),
        .SoftReset    (SoftReset),
        .req_valid    (req_valid),
        .req_hdr      (req_hdr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .c1TxAlmFull  (c1TxAlmFull),
        .c1_valid     (c1_valid),
        .c1_hdr       (c1_hdr),
        .c1_data      (c1_data),
        .stat_pkt_cnt (stat_pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: which requester owns an open packet, how many beats it still owes,
    // where the round-robin search starts, and what must appear on c1 next cycle.
    bit          m_open;
    int          m_owner;
    int          m_left;
    int          m_ptr;
    int unsigned m_cnt [N];
    bit          e_valid;
    logic [HW-1:0] e_hdr;
    logic [DW-1:0] e_data;

    // Random-traffic packet state per requester.
    int            pk_left [N];
    bit            pk_first [N];
    logic [HW-1:0] pk_hdr [N];

    function automatic logic [HW-1:0] mkHdr(input logic [3:0] typ, input logic [1:0] len,
                                            input logic [15:0] md);
        logic [HW-1:0] h;
        h          = '0;
        h[71]      = 1'b1;
        h[69:68]   = len;
        h[67:64]   = typ;
        h[57:16]   = {10'd0, $urandom()};
        h[15:0]    = md;
        return h;
    endfunction

    function automatic int hdrBeats(input logic [HW-1:0] h);
        int t;
        t = int'(h[67:64]);
        if (t == 0 || t == 1 || t == 2) return int'(h[69:68]) + 1;
        return 1;
    endfunction

    function automatic logic [DW-1:0] rndData();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic int modelGrant();
        if (m_open) return req_valid[m_owner] ? m_owner : -1;
        if (c1TxAlmFull) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_open  = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_ptr   = 0;
        e_valid = 1'b0;
        e_hdr   = '0;
        e_data  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic modelAdvance(input int g);
        e_valid = (g >= 0);
        if (g < 0) return;
        e_hdr  = req_hdr[g*HW +: HW];
        e_data = req_data[g*DW +: DW];
        if (!m_open) begin
            if (hdrBeats(e_hdr) == 1) begin
                m_cnt[g] = m_cnt[g] + 1;
                m_ptr    = (g + 1) % N;
            end else begin
                m_open  = 1'b1;
                m_owner = g;
                m_left  = hdrBeats(e_hdr) - 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_open   = 1'b0;
                m_cnt[g] = m_cnt[g] + 1;
                m_ptr    = (g + 1) % N;
            end
        end
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int g);
        logic [N-1:0] expReady;
        expReady = (g < 0) ? '0 : N'(1) << g;
        check("req_ready", req_ready, expReady);
        check("c1_valid", c1_valid, e_valid);
        if (e_valid) begin
            check("c1_hdr", c1_hdr, e_hdr);
            check("c1_data", c1_data, e_data);
        end
        for (int i = 0; i < N; i++) begin
            check("stat_pkt_cnt", stat_pkt_cnt[i*32 +: 32], STATS ? m_cnt[i] : 32'd0);
        end
    endtask

    // One clock of traffic: inputs are already driven; compare at negedge, then advance the model.
    task automatic runCycle(input bit useLit, input logic [N-1:0] lit, input string name,
                            output int g);
        @(negedge clk);
        g = modelGrant();
        checkOutput(g);
        if (useLit) check(name, req_ready, lit);
        modelAdvance(g);
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic [HW-1:0] h);
        req_valid[i]          = v;
        req_hdr[i*HW +: HW]   = h;
        req_data[i*DW +: DW]  = rndData();
    endtask

    task automatic newPacket(input int i);
        logic [3:0] typs [5];
        logic [1:0] lens [3];
        typs = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6};
        lens = '{2'b00, 2'b01, 2'b11};
        pk_hdr[i]   = mkHdr(typs[$urandom_range(0, 4)], lens[$urandom_range(0, 2)],
                            16'($urandom()));
        pk_left[i]  = hdrBeats(pk_hdr[i]);
        pk_first[i] = 1'b1;
    endtask

    task automatic doReset(input string name);
        SoftReset = 1'b1;
        #1;
        check({name, "_c1_valid"}, c1_valid, '0);
        check({name, "_c1_hdr"}, c1_hdr, '0);
        modelReset();
        @(posedge clk);
        #1;
        SoftReset = 1'b0;
    endtask

    task automatic applyStimulus();
        c1TxAlmFull = ($urandom_range(0, 99) < 20);
        for (int i = 0; i < N; i++) begin
            logic [HW-1:0] h;
            h     = pk_hdr[i];
            h[71] = pk_first[i];
            setReq(i, ($urandom_range(0, 99) < 70), h);
        end
    endtask

    initial begin
        int g;
        SoftReset   = 1'b1;
        req_valid   = '0;
        req_hdr     = '0;
        req_data    = '0;
        c1TxAlmFull = 1'b0;
        modelReset();
        #2;
        check("rst_c1_valid", c1_valid, '0);
        check("rst_c1_hdr", c1_hdr, '0);
        check("rst_c1_data", c1_data, '0);
        check("rst_req_ready", req_ready, '0);
        check("rst_stat", stat_pkt_cnt, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        SoftReset = 1'b0;

        // 1: every requester with single-CL writes -> strict rotation 0,1,2,3,0
        for (int i = 0; i < N; i++) setReq(i, 1'b1, mkHdr(4'h0, 2'b00, 16'(16'h100 + i)));
        runCycle(1'b1, 4'b0001, "t1_rr0", g);
        runCycle(1'b1, 4'b0010, "t1_rr1", g);
        runCycle(1'b1, 4'b0100, "t1_rr2", g);
        runCycle(1'b1, 4'b1000, "t1_rr3", g);
        runCycle(1'b1, 4'b0001, "t1_rr4", g);
        req_valid = '0;

        // 2: req1 4-CL burst holds the channel, then req2
        setReq(0, 1'b1, mkHdr(4'h0, 2'b00, 16'h200));
        setReq(1, 1'b1, mkHdr(4'h0, 2'b11, 16'h201));
        setReq(2, 1'b1, mkHdr(4'h0, 2'b00, 16'h202));
        for (int b = 0; b < 4; b++) begin
            setReq(1, 1'b1, mkHdr(4'h0, 2'b11, 16'(16'h210 + b)));
            runCycle(1'b1, 4'b0010, "t2_burst", g);
        end
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b0;
        runCycle(1'b1, 4'b0100, "t2_after", g);
        req_valid = '0;
        runCycle(1'b1, 4'b0000, "t2_idle", g);

        // 3: AlmFull blocks a new packet; its release grants in the same cycle
        c1TxAlmFull = 1'b1;
        setReq(0, 1'b1, mkHdr(4'h0, 2'b00, 16'h300));
        for (int c = 0; c < 3; c++) runCycle(1'b1, 4'b0000, "t3_blocked", g);
        c1TxAlmFull = 1'b0;
        runCycle(1'b1, 4'b0001, "t3_release", g);
        req_valid = '0;

        // 4: AlmFull rising mid 2-CL burst still lets the trailing beat through
        setReq(3, 1'b1, mkHdr(4'h0, 2'b01, 16'h400));
        runCycle(1'b1, 4'b1000, "t4_beat1", g);
        c1TxAlmFull = 1'b1;
        runCycle(1'b1, 4'b1000, "t4_beat2", g);
        setReq(3, 1'b1, mkHdr(4'h0, 2'b00, 16'h401));
        runCycle(1'b1, 4'b0000, "t4_hold0", g);
        runCycle(1'b1, 4'b0000, "t4_hold1", g);
        c1TxAlmFull = 1'b0;
        runCycle(1'b1, 4'b1000, "t4_release", g);
        req_valid = '0;

        // 5: reset mid 4-CL burst abandons it; arbitration restarts at requester 0
        setReq(2, 1'b1, mkHdr(4'h0, 2'b11, 16'h500));
        runCycle(1'b1, 4'b0100, "t5_beat1", g);
        runCycle(1'b1, 4'b0100, "t5_beat2", g);
        req_valid = '0;
        setReq(1, 1'b1, mkHdr(4'h0, 2'b00, 16'h501));
        setReq(3, 1'b1, mkHdr(4'h0, 2'b00, 16'h503));
        doReset("t5_rst");
        runCycle(1'b1, 4'b0010, "t5_regrant", g);
        req_valid = '0;

        // 6: req2 completes 1, 2, 4-CL writes and a fence -> four packets counted
        setReq(2, 1'b1, mkHdr(4'h0, 2'b00, 16'h600));
        runCycle(1'b1, 4'b0100, "t6_p1", g);
        setReq(2, 1'b1, mkHdr(4'h1, 2'b01, 16'h601));
        for (int b = 0; b < 2; b++) runCycle(1'b1, 4'b0100, "t6_p2", g);
        setReq(2, 1'b1, mkHdr(4'h2, 2'b11, 16'h602));
        for (int b = 0; b < 4; b++) runCycle(1'b1, 4'b0100, "t6_p4", g);
        setReq(2, 1'b1, mkHdr(4'h4, 2'b00, 16'h603));
        runCycle(1'b1, 4'b0100, "t6_fence", g);
        req_valid = '0;
        check("t6_stat2", stat_pkt_cnt[2*32 +: 32], STATS ? 32'd4 : 32'd0);

        // Randomized traffic with AlmFull noise and occasional resets
        for (int i = 0; i < N; i++) newPacket(i);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                req_valid = '0;
                doReset("rnd_rst");
                for (int i = 0; i < N; i++) newPacket(i);
            end
            applyStimulus();
            runCycle(1'b0, '0, "", g);
            if (g >= 0) begin
                pk_left[g]  = pk_left[g] - 1;
                pk_first[g] = 1'b0;
                if (pk_left[g] == 0) newPacket(g);
            end
        end
        req_valid   = '0;
        c1TxAlmFull = 1'b0;
        runCycle(1'b0, '0, "", g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
